// File: rtl/alu_exec_seq.sv
// alu_exec_seq: operand-fetch / writeback sequencer around an external
// 16-bit ALU, with an 8 x 16 register file and a persistent flag register.
module alu_exec_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [4:0]  instr_op,
    input  logic [2:0]  instr_rd,
    input  logic [2:0]  instr_rs,
    input  logic [2:0]  instr_rt,
    input  logic        instr_imm_en,
    input  logic [15:0] instr_imm,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [4:0]  alu_f,
    output logic        alu_cin,
    input  logic [15:0] alu_result,
    input  logic [5:0]  alu_status,
    output logic        done_valid,
    output logic        done_err,
    output logic [2:0]  done_rd,
    output logic [15:0] done_data,
    output logic [5:0]  flags,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPRD,
        S_EXEC,
        S_WB
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_op;
    logic [2:0]  r_rd;
    logic [2:0]  r_rs;
    logic [2:0]  r_rt;
    logic        r_imm_en;
    logic [15:0] r_imm;
    logic [15:0] r_opa;
    logic [15:0] r_opb;
    logic [15:0] r_res;
    logic [5:0]  r_stat;
    logic [5:0]  r_flags;
    logic [15:0] r_regs [8];
    logic        w_sup;
    logic        w_wb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        instr_ready = 1'b0;
        done_valid  = 1'b0;
        done_err    = 1'b0;
        done_rd     = 3'd0;
        unique case (r_state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_next = S_OPRD;
                end
            end
            S_OPRD: w_next = S_EXEC;
            S_EXEC: w_next = S_WB;
            S_WB: begin
                w_next     = S_IDLE;
                done_valid = 1'b1;
                done_err   = ~w_sup;
                done_rd    = r_rd;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_sup = 1'b0;
        case (r_op) inside
            5'h01, 5'h03, [5'h04:5'h0B], [5'h10:5'h17]: w_sup = 1'b1;
            default: w_sup = 1'b0;
        endcase
    end

    assign w_wb = (r_state == S_WB) && w_sup;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_rd     <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_imm_en <= 1'b0;
            r_imm    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_res    <= '0;
            r_stat   <= '0;
            r_flags  <= '0;
        end else begin
            if (r_state == S_IDLE && instr_valid) begin
                r_op     <= instr_op;
                r_rd     <= instr_rd;
                r_rs     <= instr_rs;
                r_rt     <= instr_rt;
                r_imm_en <= instr_imm_en;
                r_imm    <= instr_imm;
            end
            if (r_state == S_OPRD) begin
                r_opa <= r_regs[r_rs];
                r_opb <= r_imm_en ? r_imm : r_regs[r_rt];
            end
            if (r_state == S_EXEC) begin
                r_res  <= alu_result;
                r_stat <= alu_status;
            end
            if (w_wb) begin
                r_flags <= r_stat;
            end
        end
    end

    // Unsupported ops retire with an error and leave the file untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb) begin
            r_regs[r_rd] <= r_res;
        end
    end

    assign alu_a     = r_opa;
    assign alu_b     = r_opb;
    assign alu_f     = r_op;
    assign alu_cin   = r_flags[5];
    assign flags     = r_flags;
    assign done_data = w_wb ? r_res : 16'd0;
    assign dbg_data  = r_regs[dbg_addr];

endmodule

// File: tb/tb_alu_exec_seq.sv
// Randomized bench for alu_exec_seq with a behavioural ALU and an
// instruction-level reference model of registers and flags.
module tb_alu_exec_seq;

    typedef struct {
        logic [4:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic        imm_en;
        logic [15:0] imm;
    } ins_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  instr_op;
    logic [2:0]  instr_rd;
    logic [2:0]  instr_rs;
    logic [2:0]  instr_rt;
    logic        instr_imm_en;
    logic [15:0] instr_imm;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [4:0]  alu_f;
    logic        alu_cin;
    logic [15:0] alu_result;
    logic [5:0]  alu_status;
    logic        done_valid;
    logic        done_err;
    logic [2:0]  done_rd;
    logic [15:0] done_data;
    logic [5:0]  flags;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] m_regs [8];
    logic [5:0]  m_flags;
    ins_t        q[$];

    alu_exec_seq dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_rd     (instr_rd),
        .instr_rs     (instr_rs),
        .instr_rt     (instr_rt),
        .instr_imm_en (instr_imm_en),
        .instr_imm    (instr_imm),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_f        (alu_f),
        .alu_cin      (alu_cin),
        .alu_result   (alu_result),
        .alu_status   (alu_status),
        .done_valid   (done_valid),
        .done_err     (done_err),
        .done_rd      (done_rd),
        .done_data    (done_data),
        .flags        (flags),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    always #5 clk = ~clk;

    // Returns {status, result}; status = {C, Z, N, V, P(even), AC}.
    function automatic logic [21:0] alu_fn(logic [4:0] f, logic [15:0] a,
                                           logic [15:0] b, logic c);
        logic [15:0] r;
        logic [15:0] bb;
        logic        cc;
        logic [16:0] s;
        logic [4:0]  h;
        logic        co;
        logic        v;
        logic        ac;
        co = 1'b0;
        v  = 1'b0;
        ac = 1'b0;
        r  = 16'd0;
        if (f inside {[5'h04:5'h07]}) begin
            bb = f[1] ? ~b : b;
            cc = f[0] ? (f[1] ? ~c : c) : f[1];
            s  = {1'b0, a} + {1'b0, bb} + {16'd0, cc};
            h  = {1'b0, a[3:0]} + {1'b0, bb[3:0]} + {4'd0, cc};
            r  = s[15:0];
            co = s[16];
            ac = h[4];
            v  = (a[15] == bb[15]) && (r[15] != a[15]);
        end else begin
            case (f)
                5'h01: r = a;
                5'h03: r = b;
                5'h08: r = a & b;
                5'h09: r = a | b;
                5'h0A: r = a ^ b;
                5'h0B: r = ~a;
                default: r = (f[4] ? (a << f[2:0]) : (a ^ 16'hDEAD));
            endcase
        end
        return {co, (r == 16'd0), r[15], v, ~(^r), ac, r};
    endfunction

    always_comb {alu_status, alu_result} = alu_fn(alu_f, alu_a, alu_b, alu_cin);

    function automatic logic is_sup(logic [4:0] op);
        return op inside {5'h01, 5'h03, [5'h04:5'h0B], [5'h10:5'h17]};
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic ins_t mk(logic [4:0] op, logic [2:0] rd, logic [2:0] rs,
                                logic [2:0] rt, logic ie, logic [15:0] imm);
        ins_t t;
        t.op = op; t.rd = rd; t.rs = rs; t.rt = rt; t.imm_en = ie; t.imm = imm;
        return t;
    endfunction

    function automatic ins_t rnd_ins();
        return mk(5'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                  1'($urandom), 16'($urandom));
    endfunction

    task automatic drive(ins_t t);
        instr_op     = t.op;
        instr_rd     = t.rd;
        instr_rs     = t.rs;
        instr_rt     = t.rt;
        instr_imm_en = t.imm_en;
        instr_imm    = t.imm;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'd0;
        m_flags = 6'd0;
    endtask

    // Streams q with instr_valid held high; the model tracks the phase.
    task automatic run();
        int          n;
        int          idx;
        int          bsy;
        int          ndone;
        logic        acc;
        logic        sup;
        ins_t        c;
        logic [15:0] ea;
        logic [15:0] eb;
        logic [21:0] o;
        n     = q.size();
        idx   = 0;
        bsy   = 0;
        ndone = 0;
        sup   = 1'b0;
        o     = '0;
        ea    = '0;
        eb    = '0;
        c     = mk(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(q[0]);
        instr_valid = 1'b1;
        while (idx < n || bsy != 0) begin
            dbg_addr = 3'($urandom);
            #1;
            chk("dbg", dbg_data, m_regs[dbg_addr]);
            chk("ready", instr_ready, bsy == 0);
            chk("done_valid", done_valid, bsy == 3);
            chk("flags", flags, m_flags);
            chk("cin", alu_cin, m_flags[5]);
            ndone += int'(done_valid);
            if (bsy == 2) begin
                chk("alu_a", alu_a, ea);
                chk("alu_b", alu_b, eb);
                chk("alu_f", alu_f, c.op);
            end
            if (bsy == 3) begin
                chk("done_err", done_err, !sup);
                chk("done_rd", done_rd, c.rd);
                chk("done_data", done_data, sup ? o[15:0] : 16'd0);
            end
            acc = (bsy == 0) && instr_valid;
            if (acc) begin
                c   = q[idx];
                ea  = m_regs[c.rs];
                eb  = c.imm_en ? c.imm : m_regs[c.rt];
                o   = alu_fn(c.op, ea, eb, m_flags[5]);
                sup = is_sup(c.op);
                idx++;
            end
            @(posedge clk);
            #1;
            if (bsy == 3 && sup) begin
                m_regs[c.rd] = o[15:0];
                m_flags      = o[21:16];
            end
            bsy = acc ? 1 : (bsy == 0 ? 0 : (bsy + 1) % 4);
            if (acc) begin
                if (idx < n) begin
                    drive(q[idx]);
                end else begin
                    instr_valid = 1'b0;
                    drive(rnd_ins());
                end
            end
            @(negedge clk);
        end
        chk("retired", ndone, n);
        q.delete();
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        dbg_addr    = 3'd0;
        drive(mk(0, 0, 0, 0, 0, 0));
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", instr_ready, 1);
        chk("rst_flags", flags, 0);
        chk("rst_done", done_valid, 0);
        chk("rst_cin", alu_cin, 0);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            chk("rst_dbg", dbg_data, 0);
        end

        repeat (2) begin
            @(negedge clk);
            chk("idle_ready", instr_ready, 1);
            chk("idle_done", done_valid, 0);
        end

        q.push_back(mk(5'h04, 1, 0, 0, 1, 16'h7FFF));
        q.push_back(mk(5'h04, 2, 1, 0, 1, 16'h0001));
        run();
        chk("badd_flags", flags, 6'h0D);
        dbg_addr = 3'd2;
        #1;
        chk("badd_r2", dbg_data, 16'h8000);

        q.push_back(mk(5'h04, 3, 0, 0, 1, 16'hFFFF));
        q.push_back(mk(5'h04, 4, 3, 0, 1, 16'h0001));
        run();
        chk("cc_flags", flags, 6'h33);
        dbg_addr = 3'd4;
        #1;
        chk("cc_r4", dbg_data, 16'h0000);
        chk("cc_cin", alu_cin, 1);
        q.push_back(mk(5'h05, 5, 0, 0, 1, 16'h0000));
        run();
        dbg_addr = 3'd5;
        #1;
        chk("adc_r5", dbg_data, 16'h0001);

        q.push_back(mk(5'h00, 2, 1, 1, 0, 16'h1234));
        run();
        dbg_addr = 3'd2;
        #1;
        chk("err_r2", dbg_data, 16'h8000);

        for (int k = 0; k < 3; k++) q.push_back(rnd_ins());
        run();
        for (int k = 0; k < 150; k++) q.push_back(rnd_ins());
        run();

        @(negedge clk);
        drive(mk(5'h04, 6, 0, 0, 1, 16'h1234));
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_exec_f", alu_f, 5'h04);
        rst = 1'b1;
        #1;
        model_reset();
        chk("mid_ready", instr_ready, 1);
        chk("mid_done", done_valid, 0);
        chk("mid_flags", flags, 0);
        chk("mid_alu_a", alu_a, 0);
        dbg_addr = 3'd6;
        #1;
        chk("mid_r6", dbg_data, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("mid_nodone", done_valid, 0);
            chk("mid_r6_after", dbg_data, 0);
        end

        for (int k = 0; k < 20; k++) q.push_back(rnd_ins());
        run();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_seq.md
# alu_exec_seq

Sequential operand-fetch / writeback controller that sits on both sides of the combinational 16-bit ALU. It accepts one instruction per handshake, reads operands from an internal 8 x 16 register file and drives the ALU inputs (A, B, 5-bit function code, Cin). It then captures the ALU Result and 6-bit Status, writes the result back to the destination register and updates a persistent flag register whose carry bit feeds the next ALU Cin. It is a multi-cycle, non-pipelined unit: one instruction in flight at a time.

## Interface
- REG_COUNT, 8, number of 16-bit registers; fixed at 8, so register addresses are 3 bits.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  unit can accept an instruction; high only in IDLE.
- instr_op  in  5  ALU function code, passed unmodified to alu_f.
- instr_rd  in  3  destination register.
- instr_rs  in  3  source register for A.
- instr_rt  in  3  source register for B.
- instr_imm_en  in  1  when high, B comes from instr_imm instead of register rt.
- instr_imm  in  16  immediate operand.
- alu_a  out  16  to ALU A.
- alu_b  out  16  to ALU B.
- alu_f  out  5  to ALU F.
- alu_cin  out  1  to ALU Cin; always equals flags[5].
- alu_result  in  16  from ALU Result.
- alu_status  in  6  from ALU Status: bit5 C, bit4 Z, bit3 N, bit2 V, bit1 P, bit0 AC.
- done_valid  out  1  one-cycle pulse: instruction retired.
- done_err  out  1  one-cycle pulse, coincident with done_valid: op code was unsupported.
- done_rd  out  3  destination of the retired instruction.
- done_data  out  16  result written; 0 when done_err is high.
- flags  out  6  flag register, same bit layout as alu_status.
- dbg_addr  in  3  debug read address.
- dbg_data  out  16  combinational read of the register file at dbg_addr.

## Operation
- FSM has four states: IDLE -> OPRD -> EXEC -> WB -> IDLE.
- IDLE
  - instr_ready is 1.
  - On a clock edge with instr_valid=1, the unit latches op, rd, rs, rt, imm_en and imm, then moves to OPRD.
  - With instr_valid=0 it stays in IDLE.
- OPRD
  - Loads opA <= reg[rs].
  - Loads opB <= imm_en ? imm : reg[rt].
- EXEC
  - alu_a is driven from opA, alu_b from opB, alu_f from the latched op.
  - At the end of the cycle, res <= alu_result and stat <= alu_status.
- WB
  - For a supported op: the edge ending WB writes reg[rd] <= res and flags <= stat.
  - done_valid=1 for the whole WB cycle; done_rd and done_data are valid in that cycle.
  - Supported ops: 0x01, 0x03, 0x04-0x07, 0x08-0x0B, 0x10-0x17.
  - For any other op: done_valid=1 and done_err=1; no register write; flags unchanged.
- Outside EXEC, alu_a, alu_b and alu_f hold the last latched values. This is don't-care for correctness.
- The same register may be used as rd, rs and rt. The read in OPRD sees the value before this instruction's write.
- dbg_data is combinational. A write in WB is visible on dbg_data from the next cycle.

## Timing
- Latency: handshake edge to done_valid is 3 cycles (OPRD, EXEC, WB). Peak throughput is 1 instruction every 4 cycles.
- instr_ready drops the cycle after acceptance and reasserts the cycle after WB.
- If instr_valid is held high continuously, the unit accepts at cycle 0, 4, 8, ...
- instr_* fields are sampled only on the accepting edge. Later changes have no effect.
- alu_cin reflects flags as of EXEC.
  - Back-to-back ADC/SBB therefore chain correctly, because the flags write at the end of WB precedes the next EXEC.
- Reset values (asynchronous, immediate on rst):
  - State IDLE, instr_ready=1.
  - done_valid=0, done_err=0, done_rd=0, done_data=0.
  - flags=0, alu_cin=0.
  - All registers 0, so dbg_data=0.
  - opA, opB, res, stat = 0; alu_a=0, alu_b=0, alu_f=0.
- Reset asserted in any state abandons the in-flight instruction: no writeback, no done pulse.
- First acceptance after reset: the first rising edge with rst low and instr_valid high.

## Test plan
- Reset check: rst pulse -> instr_ready=1, flags=0x00, dbg_data=0 for every dbg_addr 0..7, done_valid=0.
- Boundary add:
  - Stimulus: ADD (0x04) rd=1, rs=0, imm 0x7FFF, giving r1=0x7FFF; then ADD rd=2, rs=1, imm 0x0001.
  - Response: done_data=0x8000 exactly 3 cycles after acceptance; flags=0x0D (N, V, AC); dbg r2=0x8000.
- Carry chain:
  - Stimulus: ADD r3=r0+0xFFFF; ADD r4=r3+0x0001; then ADC (0x05) r5=r0+imm 0.
  - Response after the second ADD: r4=0x0000, flags=0x33 (C, Z, P, AC).
  - Response for the ADC: alu_cin=1 during its EXEC, and r5=0x0001.
- Unsupported op:
  - Stimulus: op 0x00 with rd=2.
  - Response: done_valid=1 and done_err=1 in the same cycle; r2 and flags unchanged.
- Handshake: instr_valid held high with 3 queued instructions -> acceptances exactly 4 cycles apart; instr_ready low in OPRD, EXEC and WB; each instruction retired once, in order.
- Mid-op reset: rst asserted during EXEC of an ADD to r6 -> immediate return to IDLE; no done pulse; r6=0; flags=0.
